// File: rtl/matmul_operand_streamer.sv
// Operand sequencer for the 2x2 matrix multiplier: load X/Y, GO, then read results R.
// Latency: START registered one cycle after GO; 3 cycles minimum per result element.
// Backpressure: waits on OUT_STROBE per element; aborts with sticky ERR after TIMEOUT cycles.
module matmul_operand_streamer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        LD_EN,
  input  logic        LD_SEL,
  input  logic [1:0]  LD_ADDR,
  input  logic [7:0]  LD_DATA,
  input  logic        GO,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        START,
  output logic [7:0]  A,
  output logic [7:0]  B,
  input  logic [16:0] OUT,
  input  logic        OUT_STROBE,
  input  logic [1:0]  RD_ADDR,
  output logic [16:0] RD_DATA
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    STREAM = 2'd2,
    WAIT   = 2'd3
  } state_t;

  // Last WAIT cycle index before the element is abandoned.
  localparam logic [7:0] T_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  e_q, e_d;
  logic [7:0]  t_q, t_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        busy_q;
  logic        start_q;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        k_d;
  logic        cap_en;
  logic        ld_we;
  logic [7:0]  x_q [4];
  logic [7:0]  y_q [4];
  logic [16:0] r_q [4];
  logic [16:0] rd_q;

  // Next-state logic: element sequencing, timeout and result capture decisions.
  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    t_d     = t_q;
    err_d   = err_q;
    done_d  = 1'b0;
    cap_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (GO) begin
          state_d = ISSUE;
          e_d     = 2'd0;
          err_d   = 1'b0;
        end
      end
      ISSUE: begin
        state_d = STREAM;
      end
      STREAM: begin
        state_d = WAIT;
        t_d     = 8'd0;
      end
      WAIT: begin
        t_d = t_q + 8'd1;
        // A strobe in the final allowed cycle still counts as success.
        if (OUT_STROBE) begin
          cap_en = 1'b1;
          if (e_q == 2'd3) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            e_d     = e_q + 2'd1;
            state_d = ISSUE;
          end
        end else if (t_q == T_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand select for the coming cycle: pair k=0 in ISSUE, k=1 in STREAM, zero otherwise.
  always_comb begin
    k_d   = (state_d == STREAM);
    a_d   = 8'd0;
    b_d   = 8'd0;
    ld_we = LD_EN && (state_q == IDLE);
    if (state_d == ISSUE || state_d == STREAM) begin
      a_d = x_q[{e_d[1], k_d}];
      b_d = y_q[{k_d, e_d[0]}];
    end
  end

  // Control and output registers; outputs reflect the state entered at this edge.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q <= IDLE;
      e_q     <= 2'd0;
      t_q     <= 8'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      t_q     <= t_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
      start_q <= (state_d == ISSUE);
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Operand banks written only while idle; result bank written on accepted strobes.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      for (int n = 0; n < 4; n++) begin
        x_q[n] <= 8'd0;
        y_q[n] <= 8'd0;
        r_q[n] <= 17'd0;
      end
    end else begin
      if (ld_we) begin
        if (LD_SEL) y_q[LD_ADDR] <= LD_DATA;
        else        x_q[LD_ADDR] <= LD_DATA;
      end
      if (cap_en) r_q[e_q] <= OUT;
    end
  end

  // Registered result read port, free-running every cycle.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) rd_q <= 17'd0;
    else       rd_q <= r_q[RD_ADDR];
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR     = err_q;
  assign START   = start_q;
  assign A       = a_q;
  assign B       = b_q;
  assign RD_DATA = rd_q;

endmodule

// File: tb/tb_matmul_operand_streamer.sv
// Bench for matmul_operand_streamer: directed scenarios with a behavioural multiplier.
// Expected pairs, events and reads are queued by the stimulus; one monitor compares.
// Multiplier strobe delay, withheld element and spurious strobes are stimulus knobs.
module tb_matmul_operand_streamer;

  localparam int TO = 15;

  localparam logic [7:0] M_X1 [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
  localparam logic [7:0] M_Y1 [4] = '{8'd5, 8'd6, 8'd7, 8'd8};
  localparam logic [7:0] M_FF [4] = '{8'd255, 8'd255, 8'd255, 8'd255};
  localparam int R_S1 [4] = '{19, 22, 43, 50};
  localparam int R_FF [4] = '{130050, 130050, 130050, 130050};
  localparam int R_S3 [4] = '{19, 22, 130050, 130050};
  localparam int R_Z  [4] = '{0, 0, 0, 0};

  logic        CLK = 1'b0;
  logic        NRST;
  logic        LD_EN, LD_SEL, GO;
  logic [1:0]  LD_ADDR, RD_ADDR;
  logic [7:0]  LD_DATA;
  logic        BUSY, DONE, ERR, START;
  logic [7:0]  A, B;
  logic [16:0] OUT;
  logic        OUT_STROBE;
  logic [16:0] RD_DATA;

  typedef struct {
    bit is_err;
    int lat;
  } evt_t;

  logic [15:0] exp_ab[$];
  evt_t        exp_evt[$];
  int          exp_rd[$];

  int checks = 0;
  int errors = 0;

  logic [7:0] cur_x [4];
  logic [7:0] cur_y [4];
  int  delay    = 3;
  int  withhold = 4;
  bit  spurious = 1'b0;
  bit  rd_req   = 1'b0;
  bit  end_req  = 1'b0;

  always #5 CLK = ~CLK;

  matmul_operand_streamer #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .NRST(NRST),
    .LD_EN(LD_EN), .LD_SEL(LD_SEL), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
    .GO(GO), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .START(START), .A(A), .B(B),
    .OUT(OUT), .OUT_STROBE(OUT_STROBE),
    .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA)
  );

  // Behavioural multiplier: captures the two pairs, answers after 'delay' WAIT cycles.
  int          m_cnt = 0;
  int          m_e = 0;
  bit          m_phase = 1'b0;
  logic [7:0]  m_a0, m_b0;
  logic [16:0] m_sum;
  always @(negedge CLK) begin
    OUT_STROBE = 1'b0;
    OUT        = 17'd0;
    if (!NRST) begin
      m_phase = 1'b0;
      m_cnt   = 0;
    end else begin
      if (!BUSY) m_e = 0;
      if (START) begin
        m_a0 = A; m_b0 = B; m_phase = 1'b1;
        if (spurious) begin OUT_STROBE = 1'b1; OUT = 17'h1ABCD; end
      end else if (m_phase) begin
        m_phase = 1'b0;
        m_sum = 17'(m_a0) * 17'(m_b0) + 17'(A) * 17'(B);
        if (m_e != withhold) m_cnt = delay;
        m_e++;
        if (spurious) begin OUT_STROBE = 1'b1; OUT = 17'h1ABCD; end
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin OUT_STROBE = 1'b1; OUT = m_sum; end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  int   cyc = 0, first_start = 0, last_start = 0;
  bit   in_seq = 1'b0, mon_phase = 1'b0, err_prev = 1'b0, nrst_prev = 1'b1;
  evt_t ev;

  task automatic chk_pair(input string nm);
    if (exp_ab.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: unexpected operand pair A=%0d B=%0d at %0t", nm, A, B, $time);
    end else begin
      chk(nm, int'({A, B}), int'(exp_ab.pop_front()));
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK or negedge NRST);
      #1;
      if (!NRST) begin
        if (nrst_prev) begin
          chk("rst_ctrl", int'({START, BUSY, DONE, ERR}), 0);
          chk("rst_ab", int'({A, B}), 0);
          chk("rst_rd", int'(RD_DATA), 0);
          exp_ab.delete();
          exp_evt.delete();
        end
        nrst_prev = 1'b0; mon_phase = 1'b0; in_seq = 1'b0; err_prev = 1'b0;
      end else begin
        nrst_prev = 1'b1;
        cyc++;
        if (START) begin
          if (!in_seq) begin in_seq = 1'b1; first_start = cyc; end
          last_start = cyc;
          chk_pair("pair_k0");
          mon_phase = 1'b1;
        end else if (mon_phase) begin
          chk_pair("pair_k1");
          mon_phase = 1'b0;
        end
        if (DONE) begin
          if (exp_evt.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected: DONE=1 expected no event at %0t", $time);
          end else begin
            ev = exp_evt.pop_front();
            chk("done_kind_is_err", 0, int'(ev.is_err));
            if (ev.lat >= 0) chk("done_latency", cyc - first_start, ev.lat);
            chk("done_busy_err", int'({BUSY, ERR}), 0);
          end
          in_seq = 1'b0;
        end
        if (ERR && !err_prev) begin
          if (exp_evt.size() == 0) begin
            checks++; errors++;
            $display("FAIL err_unexpected: ERR=1 expected no event at %0t", $time);
          end else begin
            ev = exp_evt.pop_front();
            chk("err_kind_is_err", 1, int'(ev.is_err));
            chk("err_wait_cycles", cyc - last_start - 2, ev.lat);
            chk("err_busy", int'(BUSY), 0);
          end
          in_seq = 1'b0;
        end
        err_prev = ERR;
        if (rd_req) begin
          if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: RD_DATA=%0d no expectation", RD_DATA);
          end else begin
            chk("rd_data", int'(RD_DATA), exp_rd.pop_front());
          end
        end
        if (end_req) begin
          chk("pairs_left", exp_ab.size(), 0);
          chk("events_left", exp_evt.size(), 0);
          chk("reads_left", exp_rd.size(), 0);
          $display("Simulation finished: %0d checks, %0d errors", checks, errors);
          $finish;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic load_all(input logic [7:0] xv [4], input logic [7:0] yv [4]);
    for (int n = 0; n < 4; n++) begin
      @(negedge CLK); LD_EN = 1'b1; LD_SEL = 1'b0; LD_ADDR = 2'(n); LD_DATA = xv[n];
    end
    for (int n = 0; n < 4; n++) begin
      @(negedge CLK); LD_EN = 1'b1; LD_SEL = 1'b1; LD_ADDR = 2'(n); LD_DATA = yv[n];
    end
    @(negedge CLK); LD_EN = 1'b0;
    cur_x = xv;
    cur_y = yv;
  endtask

  task automatic push_seq(input int n_elems);
    for (int e = 0; e < n_elems; e++)
      for (int k = 0; k < 2; k++)
        exp_ab.push_back({cur_x[(e / 2) * 2 + k], cur_y[k * 2 + (e % 2)]});
  endtask

  task automatic push_evt(input bit is_err, input int lat);
    evt_t t;
    t.is_err = is_err;
    t.lat    = lat;
    exp_evt.push_back(t);
  endtask

  task automatic go_pulse();
    @(negedge CLK); GO = 1'b1;
    @(negedge CLK); GO = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 300; c++) begin
      if (!BUSY) break;
      @(negedge CLK);
    end
  endtask

  task automatic read_all(input int r [4]);
    for (int n = 0; n < 4; n++) begin
      @(negedge CLK); RD_ADDR = 2'(n); rd_req = 1'b1; exp_rd.push_back(r[n]);
    end
    @(negedge CLK); rd_req = 1'b0;
  endtask

  int starts_seen;

  initial begin
    NRST = 1'b1; GO = 1'b0; LD_EN = 1'b0; LD_SEL = 1'b0;
    LD_ADDR = 2'd0; LD_DATA = 8'd0; RD_ADDR = 2'd0;
    #1 NRST = 1'b0;
    repeat (3) @(negedge CLK);
    NRST = 1'b1;
    read_all(R_Z);

    // 1: basic product, strobe three WAIT cycles in
    load_all(M_X1, M_Y1);
    delay = 3; push_seq(4); push_evt(1'b0, 20);
    go_pulse(); wait_idle();
    read_all(R_S1);

    // 2: full-scale operands
    load_all(M_FF, M_FF);
    delay = 2; push_seq(4); push_evt(1'b0, 16);
    go_pulse(); wait_idle();
    read_all(R_FF);

    // 3: element 2 never answered -> timeout abort, earlier results kept
    load_all(M_X1, M_Y1);
    delay = 3; withhold = 2; push_seq(3); push_evt(1'b1, TO);
    go_pulse(); wait_idle();
    withhold = 4;
    read_all(R_S3);

    // 4: GO/LD_EN during BUSY and strobes in ISSUE/STREAM are ignored; GO clears ERR
    spurious = 1'b1; push_seq(4); push_evt(1'b0, 20);
    go_pulse();
    repeat (2) @(negedge CLK);
    GO = 1'b1; LD_EN = 1'b1; LD_SEL = 1'b1; LD_ADDR = 2'd2; LD_DATA = 8'hEE;
    repeat (8) @(negedge CLK);
    GO = 1'b0; LD_EN = 1'b0;
    wait_idle();
    spurious = 1'b0;
    read_all(R_S1);

    // 5: reset during element 1 WAIT
    push_seq(2);
    go_pulse();
    starts_seen = 1;
    for (int c = 0; c < 50 && starts_seen < 2; c++) begin
      @(negedge CLK);
      if (START) starts_seen++;
    end
    repeat (2) @(negedge CLK);
    NRST = 1'b0;
    repeat (3) @(negedge CLK);
    NRST = 1'b1;
    read_all(R_Z);
    load_all(M_X1, M_Y1);
    delay = 3; push_seq(4); push_evt(1'b0, 20);
    go_pulse(); wait_idle();
    read_all(R_S1);

    // 6: fastest strobe, GO held high across DONE restarts the sequence
    delay = 1; push_seq(4); push_evt(1'b0, 12); push_seq(4); push_evt(1'b0, 12);
    @(negedge CLK); GO = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (DONE) break;
    end
    @(negedge CLK); GO = 1'b0;
    wait_idle();
    read_all(R_S1);

    repeat (3) @(negedge CLK);
    end_req = 1'b1;
    repeat (10) @(negedge CLK);
    $display("FAIL summary_not_reached: monitor did not finish");
    $fatal(1);
  end

endmodule
